// File: rtl/bp_pkg.sv
// Shared constants and helpers for the gshare/bimodal direction predictor.
package bp_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // Saturating +/-1 on a counter of up to 4 bits; width selects the ceiling.
    function automatic logic [3:0] sat_update(input logic [3:0] ctr, input logic taken, input int width);
        logic [3:0] max_v;
        max_v = 4'((32'd1 << width) - 32'd1);
        if (taken)
            return (ctr == max_v) ? ctr : ctr + 4'd1;
        else
            return (ctr == 4'd0) ? ctr : ctr - 4'd1;
    endfunction

    // Table index: word-aligned PC bits, optionally folded with zero-extended history.
    function automatic logic [31:0] bp_index(input logic [31:0] pc, input logic [31:0] ghr,
                                             input int scale, input int mode);
        logic [31:0] mask;
        mask = (32'd1 << scale) - 32'd1;
        return ((pc >> 2) ^ ((mode == MODE_GSHARE) ? ghr : 32'd0)) & mask;
    endfunction

endpackage

// File: rtl/bp_counter_ram.sv
// Counter table: one read port with registered, enable-held output and one write port.
// A read and write to the same address on one edge returns the written data.
module bp_counter_ram #(
    parameter int              ADDR_W  = 10,
    parameter int              DATA_W  = 2,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_rdata <= RST_VAL;
        else if (i_re)
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/branch_predictor_gshare.sv
// Direction predictor: saturating-counter table indexed by PC or PC^GHR, with a
// speculative global history, mispredict recovery and a post-reset init sweep.
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int SCALE     = 10,
    parameter int CTR_WIDTH = 2,
    parameter int GHR_WIDTH = 8,
    parameter int MODE      = 1,
    parameter int INIT      = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_ready,
    input  logic                 i_bp_oe,
    input  logic [31:0]          i_bp_pc,
    output logic                 o_bp_taken,
    output logic [CTR_WIDTH-1:0] o_bp_data,
    output logic [GHR_WIDTH-1:0] o_bp_ghr,
    input  logic                 i_bp_shift,
    input  logic                 i_fb_we,
    input  logic [31:0]          i_fb_pc,
    input  logic                 i_fb_taken,
    input  logic [CTR_WIDTH-1:0] i_fb_data,
    input  logic [GHR_WIDTH-1:0] i_fb_ghr,
    input  logic                 i_fb_mispredict
);

    logic                 r_ready;
    logic [SCALE-1:0]     r_sweep_idx;
    logic [GHR_WIDTH-1:0] r_ghr;
    logic [GHR_WIDTH-1:0] r_bp_ghr;
    logic                 r_taken_valid;

    logic [31:0]          w_bp_idx_full;
    logic [31:0]          w_fb_idx_full;
    logic [3:0]           w_fb_next_full;
    logic [SCALE-1:0]     w_waddr;
    logic [CTR_WIDTH-1:0] w_wdata;
    logic [CTR_WIDTH-1:0] w_rdata;
    logic [GHR_WIDTH-1:0] w_fb_hist;
    logic [GHR_WIDTH-1:0] w_bp_hist;
    logic                 w_lookup;
    logic                 w_update;
    logic                 w_we;

    assign w_lookup = r_ready & i_bp_oe;
    assign w_update = r_ready & i_fb_we;

    assign w_bp_idx_full  = bp_index(i_bp_pc, 32'(r_ghr), SCALE, MODE);
    assign w_fb_idx_full  = bp_index(i_fb_pc, 32'(i_fb_ghr), SCALE, MODE);
    assign w_fb_next_full = sat_update(4'(i_fb_data), i_fb_taken, CTR_WIDTH);

    // The init sweep owns the write port until the table is ready.
    assign w_we    = ~r_ready | w_update;
    assign w_waddr = r_ready ? w_fb_idx_full[SCALE-1:0] : r_sweep_idx;
    assign w_wdata = r_ready ? w_fb_next_full[CTR_WIDTH-1:0] : CTR_WIDTH'(INIT);

    generate
        if (GHR_WIDTH == 1) begin : g_hist_one
            assign w_fb_hist = i_fb_taken;
            assign w_bp_hist = o_bp_taken;
        end else begin : g_hist_many
            assign w_fb_hist = {i_fb_ghr[GHR_WIDTH-2:0], i_fb_taken};
            assign w_bp_hist = {r_ghr[GHR_WIDTH-2:0], o_bp_taken};
        end
    endgenerate

    bp_counter_ram #(
        .ADDR_W  (SCALE),
        .DATA_W  (CTR_WIDTH),
        .RST_VAL (CTR_WIDTH'(INIT))
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_re    (w_lookup),
        .i_raddr (w_bp_idx_full[SCALE-1:0]),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ready       <= 1'b0;
            r_sweep_idx   <= '0;
            r_ghr         <= '0;
            r_bp_ghr      <= '0;
            r_taken_valid <= 1'b0;
        end else begin
            if (!r_ready) begin
                r_sweep_idx <= r_sweep_idx + SCALE'(1);
                if (&r_sweep_idx)
                    r_ready <= 1'b1;
            end
            if (w_lookup) begin
                r_bp_ghr      <= r_ghr;
                r_taken_valid <= 1'b1;
            end
            // Recovery from a mispredict outranks the speculative shift.
            if (w_update && i_fb_mispredict)
                r_ghr <= w_fb_hist;
            else if (r_ready && i_bp_shift)
                r_ghr <= w_bp_hist;
        end
    end

    // bp_taken reads 0 until the first lookup, even if INIT has its MSB set.
    assign o_ready    = r_ready;
    assign o_bp_data  = w_rdata;
    assign o_bp_taken = r_taken_valid & w_rdata[CTR_WIDTH-1];
    assign o_bp_ghr   = r_bp_ghr;

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised successor to the core's bimodal branch predictor: a table of saturating counters, indexed bimodally (PC only) or gshare (PC XOR global history).
- Holds a speculative global history register (GHR) with single-cycle recovery on mispredict.
- Adds a reset-time table-initialisation sweep and same-index read/write bypass.
- Sits beside the BTB: prediction is read in IF and consumed in ID; feedback is applied in EM.

Parameters:
- SCALE, 10: log2 of table entries; index = pc[2+:SCALE].
- CTR_WIDTH, 2: counter width, 1..4.
- GHR_WIDTH, 8: history bits, 1..SCALE.
- MODE, 1: 0 = bimodal (GHR ignored for indexing), 1 = gshare.
- INIT, 1: counter reset value, must be < 2**CTR_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ready  out  1  table initialised; 0 during sweep.
- bp_oe  in  1  register a lookup this cycle.
- bp_pc  in  32  lookup PC.
- bp_taken  out  1  predicted direction (counter MSB).
- bp_data  out  CTR_WIDTH  counter value read; pipeline carries it to fb_data.
- bp_ghr  out  GHR_WIDTH  GHR used to form the presented lookup's index; pipeline carries it to fb_ghr.
- bp_shift  in  1  ID holds a live control transfer; shift bp_taken into GHR.
- fb_we  in  1  resolve a control transfer.
- fb_pc  in  32  resolving PC.
- fb_taken  in  1  actual direction.
- fb_data  in  CTR_WIDTH  counter value carried from lookup.
- fb_ghr  in  GHR_WIDTH  history carried from lookup.
- fb_mispredict  in  1  direction mispredicted; restore GHR.

Behaviour:
- Reset (async):
  - ready=0, bp_taken=0, bp_data=INIT, bp_ghr=0, GHR=0, sweep counter=0.
  - Reset asserted mid-sweep restarts the sweep from entry 0.
- Sweep:
  - After rst deasserts, one entry per cycle is written with INIT, entries 0..2**SCALE-1.
  - ready rises on the cycle after the last write, i.e. 2**SCALE cycles after release.
  - While ready=0: bp_oe, bp_shift and fb_we are ignored and outputs hold their reset values.
- Index:
  - idx(pc,h) = pc[2+:SCALE] XOR (MODE ? zero-extend(h) to SCALE bits : 0).
  - Lookups use the current GHR; feedback uses fb_ghr.
- Lookup, 1-cycle latency:
  - bp_oe=1 at edge t: bp_data=table[idx], bp_taken=bp_data[CTR_WIDTH-1], bp_ghr=GHR, all valid after edge t.
  - With bp_oe=0, all three outputs hold their previous values.
- Update when fb_we=1:
  - table[idx(fb_pc,fb_ghr)] <= sat(fb_data ± 1): +1 if fb_taken, else -1.
  - Saturates at 0 and 2**CTR_WIDTH-1.
  - The new value is computed from the carried fb_data, not from a table re-read.
- Collision: lookup and update to the same index on the same edge return the updated value (write-first bypass).
- GHR, priority order:
  - fb_we && fb_mispredict: GHR <= {fb_ghr[GHR_WIDTH-2:0], fb_taken}.
  - else bp_shift: GHR <= {GHR[GHR_WIDTH-2:0], bp_taken}.
  - else hold.
  - With GHR_WIDTH=1 the shift degenerates to GHR <= new bit.
- A simultaneous bp_oe uses the pre-update GHR (the value before the edge).
- fb_mispredict without fb_we has no effect.

Decomposition:
- Shared package bp_pkg:
  - MODE_BIMODAL=0, MODE_GSHARE=1.
  - function sat_update(ctr, taken, width).
  - function bp_index(pc, ghr, scale, mode).
- Sub-module bp_counter_ram:
  - Single read port and single write port, 1-cycle read, read-enable hold, write-first bypass.
  - Sweep write mux lives in the top module.

Test Plan:
- Sweep: SCALE=4, INIT=1, release rst -> ready rises exactly 16 cycles later; lookups at pc 0x00..0x3C all return bp_data=1, bp_taken=0.
- Saturation: pc=0x40, MODE=0, four fb_we/fb_taken=1 updates each feeding back the last bp_data -> bp_data 2,3,3,3 with bp_taken=1; then three not-taken -> 2,1,0.
- Bypass: same cycle bp_oe pc=0x80 and fb_we pc=0x80, fb_data=1, fb_taken=1 -> next-cycle bp_data=2.
- Gshare: MODE=1, GHR=8'h03, pc=0x10 (index 4) -> table index 7 is read; with MODE=0 index 4 is read.
- Recovery: GHR=8'hA5, same cycle bp_shift=1 (bp_taken=1) and fb_we=1, fb_mispredict=1, fb_ghr=8'h12, fb_taken=0 -> GHR=8'h24.
- Reset mid-sweep: assert rst at sweep cycle 9 of 16, release -> ready after 16 more cycles; all entries read INIT, including entries written before the abort.
